// File: rtl/pipe_barrel_shifter_if.sv
// Request/result bundle for the pipelined barrel shifter.
// The shifter is the slave of this interface; the caller is the master.
interface pipe_barrel_shifter_if #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [2:0]         in_op;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag, busy
  );

  modport master (
    output in_valid, in_data, in_shamt, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag, busy
  );
endinterface

// File: rtl/pipe_barrel_shifter.sv
// Pipelined barrel shifter: one log2 shift level per stage, MSB level first,
// with per-stage valid/ready flow control and a tag carried alongside.
module pipe_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int TAG_W   = 5
) (
  input  logic                clock,
  input  logic                reset,
  pipe_barrel_shifter_if.slave bus
);
  localparam int L = SHAMT_W - 1;

  logic [SHAMT_W-1:0] v_q, v_d, en, src_v;
  logic [WIDTH-1:0]   data_q [SHAMT_W];
  logic [WIDTH-1:0]   data_d [SHAMT_W];
  logic [WIDTH-1:0]   src_d  [SHAMT_W];
  logic [SHAMT_W-1:0] sh_q   [SHAMT_W];
  logic [SHAMT_W-1:0] sh_d   [SHAMT_W];
  logic [SHAMT_W-1:0] src_sh [SHAMT_W];
  logic [2:0]         op_q   [SHAMT_W];
  logic [2:0]         op_d   [SHAMT_W];
  logic [2:0]         src_op [SHAMT_W];
  logic [TAG_W-1:0]   tag_q  [SHAMT_W];
  logic [TAG_W-1:0]   tag_d  [SHAMT_W];
  logic [TAG_W-1:0]   src_t  [SHAMT_W];

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       op,
    input int               amt
  );
    logic [WIDTH-1:0] r;
    r = d;
    unique case (1'b1)
      op == 3'd0: r = d << amt;
      op == 3'd1: r = d >> amt;
      op == 3'd2: r = $signed(d) >>> amt;
      op == 3'd3: r = (d << amt) | (d >> (WIDTH - amt));
      op == 3'd4: r = (d >> amt) | (d << (WIDTH - amt));
      default:    r = d;
    endcase
    return r;
  endfunction

  // en[k]: stage k can load this cycle (empty, or its content moves on).
  always_comb begin
    logic acc;
    acc   = bus.out_ready || !v_q[L];
    en[L] = acc;
    for (int k = L - 1; k >= 0; k--) begin
      acc   = acc || !v_q[k];
      en[k] = acc;
    end
  end

  always_comb begin
    src_v     = {v_q[L-1:0], bus.in_valid};
    src_d[0]  = bus.in_data;
    src_sh[0] = bus.in_shamt;
    src_op[0] = bus.in_op;
    src_t[0]  = bus.in_tag;
    for (int k = 1; k < SHAMT_W; k++) begin
      src_d[k]  = data_q[k-1];
      src_sh[k] = sh_q[k-1];
      src_op[k] = op_q[k-1];
      src_t[k]  = tag_q[k-1];
    end
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    sh_d   = sh_q;
    op_d   = op_q;
    tag_d  = tag_q;
    for (int k = 0; k < SHAMT_W; k++) begin
      if (en[k]) begin
        v_d[k] = src_v[k];
        if (src_v[k]) begin
          data_d[k] = src_sh[k][L-k]
                    ? step(src_d[k], src_op[k], 1 << (L - k))
                    : src_d[k];
          sh_d[k]   = src_sh[k];
          op_d[k]   = src_op[k];
          tag_d[k]  = src_t[k];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < SHAMT_W; k++) begin
        data_q[k] <= '0;
        sh_q[k]   <= '0;
        op_q[k]   <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      sh_q   <= sh_d;
      op_q   <= op_d;
      tag_q  <= tag_d;
    end
  end

  assign bus.in_ready  = !reset && en[0];
  assign bus.out_valid = v_q[L];
  assign bus.out_data  = data_q[L];
  assign bus.out_tag   = tag_q[L];
  assign bus.busy      = |v_q;
endmodule
